modexp_sequencer: RTL and testbench

- Top-level sequencer for RSA modular exponentiation (result = base^exp mod M) in the Montgomery domain.
- Drives two shared cores through start/done handshakes: the Montgomery constant generator (produces R_r = R mod M and R_t = R^2 mod M, with R = 2^WIDTH) and a Montgomery multiplier (computes a*b*R^-1 mod M).
- Performs constant-time square-and-multiply-always over every exponent bit.
- Caches the constants so back-to-back operations under the same modulus skip regeneration.

---
 rtl/modexp_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_modexp_sequencer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_sequencer.sv
// Montgomery-domain modular exponentiation sequencer.
// Constant-time square-and-multiply-always; constants cached per modulus.
module modexp_sequencer #(
  parameter int WIDTH     = 4096,
  parameter int EXP_WIDTH = 4096,
  parameter int CNT_W     = 13
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [WIDTH-1:0]     modulus,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exponent,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH-1:0]     result,
  output logic                 const_start,
  output logic [WIDTH-1:0]     const_modulus,
  input  logic                 const_done,
  input  logic [WIDTH-1:0]     const_r_r,
  input  logic [WIDTH-1:0]     const_r_t,
  output logic                 mm_start,
  output logic [WIDTH-1:0]     mm_a,
  output logic [WIDTH-1:0]     mm_b,
  output logic [WIDTH-1:0]     mm_modulus,
  input  logic                 mm_done,
  input  logic [WIDTH-1:0]     mm_result
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CONST,
    S_TOMONT,
    S_SQR,
    S_MUL,
    S_FROMMONT
  } state_e;

  state_e               state_q, state_d;
  logic                 pend_q, pend_d;
  logic [WIDTH-1:0]     mod_q, mod_d;
  logic [WIDTH-1:0]     base_q, base_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0]     rr_q, rr_d;
  logic [WIDTH-1:0]     rt_q, rt_d;
  logic [WIDTH-1:0]     cmod_q, cmod_d;
  logic                 cvalid_q, cvalid_d;
  logic [WIDTH-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]     bm_q, bm_d;
  logic [CNT_W-1:0]     bit_q, bit_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic mm_state;
  logic mm_ack;
  logic exp_bit;

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    mod_d       = mod_q;
    base_d      = base_q;
    exp_d       = exp_q;
    rr_d        = rr_q;
    rt_d        = rt_q;
    cmod_d      = cmod_q;
    cvalid_d    = cvalid_q;
    acc_d       = acc_q;
    bm_d        = bm_q;
    bit_d       = bit_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    const_start = 1'b0;
    mm_a        = '0;
    mm_b        = '0;

    // pend_q marks "request issued, awaiting done"; a done
    // coinciding with the start pulse is never accepted
    mm_state = (state_q == S_TOMONT) || (state_q == S_SQR) ||
               (state_q == S_MUL) || (state_q == S_FROMMONT);
    mm_start = mm_state && !pend_q;
    mm_ack   = mm_state && pend_q && mm_done;
    exp_bit  = |(exp_q & (EXP_WIDTH'(1) << bit_q));

    if (mm_start) pend_d = 1'b1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mod_d  = modulus;
          base_d = base;
          exp_d  = exponent;
          busy_d = 1'b1;
          pend_d = 1'b0;
          if (cvalid_q && (modulus == cmod_q)) state_d = S_TOMONT;
          else state_d = S_CONST;
        end
      end
      S_CONST: begin
        if (!pend_q) begin
          const_start = 1'b1;
          pend_d      = 1'b1;
        end else if (const_done) begin
          rr_d     = const_r_r;
          rt_d     = const_r_t;
          cvalid_d = 1'b1;
          cmod_d   = mod_q;
          pend_d   = 1'b0;
          state_d  = S_TOMONT;
        end
      end
      S_TOMONT: begin
        mm_a = base_q;
        mm_b = rt_q;
        if (mm_ack) begin
          bm_d    = mm_result;
          acc_d   = rr_q;
          bit_d   = CNT_W'(EXP_WIDTH - 1);
          pend_d  = 1'b0;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        mm_a = acc_q;
        mm_b = acc_q;
        if (mm_ack) begin
          acc_d   = mm_result;
          pend_d  = 1'b0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        mm_a = acc_q;
        mm_b = bm_q;
        if (mm_ack) begin
          pend_d = 1'b0;
          if (exp_bit) acc_d = mm_result;
          if (bit_q == '0) begin
            state_d = S_FROMMONT;
          end else begin
            bit_d   = bit_q - CNT_W'(1);
            state_d = S_SQR;
          end
        end
      end
      S_FROMMONT: begin
        mm_a = acc_q;
        mm_b = WIDTH'(1);
        if (mm_ack) begin
          result_d = mm_result;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          pend_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pend_q   <= 1'b0;
      mod_q    <= '0;
      base_q   <= '0;
      exp_q    <= '0;
      rr_q     <= '0;
      rt_q     <= '0;
      cmod_q   <= '0;
      cvalid_q <= 1'b0;
      acc_q    <= '0;
      bm_q     <= '0;
      bit_q    <= '0;
      result_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mod_q    <= mod_d;
      base_q   <= base_d;
      exp_q    <= exp_d;
      rr_q     <= rr_d;
      rt_q     <= rt_d;
      cmod_q   <= cmod_d;
      cvalid_q <= cvalid_d;
      acc_q    <= acc_d;
      bm_q     <= bm_d;
      bit_q    <= bit_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign result        = result_q;
  assign const_modulus = mod_q;
  assign mm_modulus    = mod_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Bench for modexp_sequencer: 8-bit operands, behavioural cores,
// results checked against plain modular exponentiation.
module tb_modexp_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] modulus = '0;
  logic [7:0] base = '0;
  logic [7:0] exponent = '0;
  logic       busy, done;
  logic [7:0] result;
  logic       const_start;
  logic [7:0] const_modulus;
  logic       const_done = 1'b0;
  logic [7:0] const_r_r = '0;
  logic [7:0] const_r_t = '0;
  logic       mm_start;
  logic [7:0] mm_a, mm_b, mm_modulus;
  logic       mm_done = 1'b0;
  logic [7:0] mm_result = '0;

  int nvec = 0;
  int nerr = 0;
  int mm_total = 0;
  int cs_total = 0;
  int width_err = 0;
  int stab_err = 0;
  logic [7:0] cache_m = '0;

  modexp_sequencer #(.WIDTH(8), .EXP_WIDTH(8), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .modulus(modulus), .base(base), .exponent(exponent),
    .busy(busy), .done(done), .result(result),
    .const_start(const_start), .const_modulus(const_modulus),
    .const_done(const_done), .const_r_r(const_r_r),
    .const_r_t(const_r_t),
    .mm_start(mm_start), .mm_a(mm_a), .mm_b(mm_b),
    .mm_modulus(mm_modulus), .mm_done(mm_done),
    .mm_result(mm_result)
  );

  always #5 clk = ~clk;

  // a*b*R^-1 mod m, R = 256, by searching for the unique x
  function automatic logic [7:0] mont(input logic [7:0] a, b, m);
    int p;
    p = (int'(a) * int'(b)) % int'(m);
    for (int x = 0; x < int'(m); x++)
      if (((x * 256) % int'(m)) == p) return 8'(x);
    return 8'd0;
  endfunction

  function automatic logic [7:0] modpow(input logic [7:0] m, b, e);
    int r;
    r = 1 % int'(m);
    for (int i = 0; i < int'(e); i++) r = (r * int'(b)) % int'(m);
    return 8'(r);
  endfunction

  int mm_t = 0;
  logic [7:0] la, lb, lm;
  logic mm_prev = 1'b0;
  always @(posedge clk) begin
    mm_done <= 1'b0;
    if (!rst_n) begin
      mm_t <= 0;
    end else if (mm_start) begin
      mm_t <= 3;
      la <= mm_a;
      lb <= mm_b;
      lm <= mm_modulus;
      mm_total++;
    end else if (mm_t > 0) begin
      if (mm_a !== la || mm_b !== lb) stab_err++;
      mm_t <= mm_t - 1;
      if (mm_t == 1) begin
        mm_done <= 1'b1;
        mm_result <= mont(la, lb, lm);
      end
    end
    if (mm_start && mm_prev) width_err++;
    mm_prev <= mm_start;
  end

  int cs_t = 0;
  logic [7:0] cm;
  logic cs_prev = 1'b0;
  always @(posedge clk) begin
    const_done <= 1'b0;
    if (!rst_n) begin
      cs_t <= 0;
    end else if (const_start) begin
      cs_t <= 5;
      cm <= const_modulus;
      cs_total++;
    end else if (cs_t > 0) begin
      cs_t <= cs_t - 1;
      if (cs_t == 1) begin
        const_done <= 1'b1;
        const_r_r <= 8'(256 % int'(cm));
        const_r_t <= 8'(65536 % int'(cm));
      end
    end
    if (const_start && cs_prev) width_err++;
    cs_prev <= const_start;
  end

  // Called at a negedge; returns at the negedge after done.
  task automatic run_op(input logic [7:0] m, b, e, input int inj,
                        output logic [7:0] res, output int cyc,
                        output int mmd, output int csd,
                        output logic b1, output logic bdone,
                        output logic dnext, output logic bnext,
                        output logic got);
    int mm0, cs0;
    mm0 = mm_total;
    cs0 = cs_total;
    modulus = m;
    base = b;
    exponent = e;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    modulus = 8'($urandom);
    base = 8'($urandom);
    exponent = 8'($urandom);
    b1 = busy;
    cyc = 1;
    got = 1'b0;
    res = '0;
    bdone = 1'b0;
    dnext = 1'b0;
    bnext = 1'b0;
    while (!got && cyc < 400) begin
      if (cyc == inj) begin
        start = 1'b1;
        base = 8'd3;
        modulus = 8'd221;
        exponent = 8'hFF;
      end
      @(negedge clk);
      start = 1'b0;
      cyc++;
      if (done) got = 1'b1;
    end
    if (got) begin
      res = result;
      bdone = busy;
      @(negedge clk);
      dnext = done;
      bnext = busy;
    end
    mmd = mm_total - mm0;
    csd = cs_total - cs0;
  endtask

  logic [7:0] res;
  int cyc, mmd, csd;
  logic b1, bdone, dnext, bnext, got;

  task automatic test_reset();
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    nvec++;
    if ({busy, done, const_start, mm_start} !== 4'b0) begin
      nerr++;
      $display("FAIL reset_ctrl got %b want 0000",
               {busy, done, const_start, mm_start});
    end
    nvec++;
    if (result !== 8'd0) begin
      nerr++;
      $display("FAIL reset_result got %0d want 0", result);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first();
    run_op(8'd187, 8'd5, 8'h07, 0, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    nvec++;
    if (!got || res !== modpow(8'd187, 8'd5, 8'h07)) begin
      nerr++;
      $display("FAIL first_result got %0d want %0d (done %b)",
               res, modpow(8'd187, 8'd5, 8'h07), got);
    end
    nvec++;
    if (csd != 1 || mmd != 18) begin
      nerr++;
      $display("FAIL first_counts got cs=%0d mm=%0d want 1 18",
               csd, mmd);
    end
    nvec++;
    if ({b1, bdone, dnext, bnext} !== 4'b1000) begin
      nerr++;
      $display("FAIL first_busy_done got %b want 1000",
               {b1, bdone, dnext, bnext});
    end
    cache_m = 8'd187;
  endtask

  task automatic test_cached();
    run_op(8'd187, 8'd2, 8'h0A, 0, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    nvec++;
    if (!got || res !== 8'd89) begin
      nerr++;
      $display("FAIL cached_result got %0d want 89", res);
    end
    nvec++;
    if (csd != 0 || mmd != 18) begin
      nerr++;
      $display("FAIL cached_counts got cs=%0d mm=%0d want 0 18",
               csd, mmd);
    end
  endtask

  task automatic test_latency();
    int c0;
    logic [7:0] r0;
    run_op(8'd187, 8'd9, 8'h00, 0, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    c0 = cyc;
    r0 = res;
    nvec++;
    if (!got || r0 !== 8'd1) begin
      nerr++;
      $display("FAIL exp0_result got %0d want 1", r0);
    end
    run_op(8'd187, 8'd9, 8'hFF, 0, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    nvec++;
    if (!got || res !== modpow(8'd187, 8'd9, 8'hFF)) begin
      nerr++;
      $display("FAIL expff_result got %0d want %0d",
               res, modpow(8'd187, 8'd9, 8'hFF));
    end
    nvec++;
    if (cyc != c0) begin
      nerr++;
      $display("FAIL latency got %0d cycles want %0d", cyc, c0);
    end
  endtask

  task automatic test_busy_start();
    run_op(8'd187, 8'd7, 8'h5B, 4, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    nvec++;
    if (!got || res !== modpow(8'd187, 8'd7, 8'h5B)) begin
      nerr++;
      $display("FAIL busy_start_result got %0d want %0d",
               res, modpow(8'd187, 8'd7, 8'h5B));
    end
    nvec++;
    if (csd != 0 || mmd != 18) begin
      nerr++;
      $display("FAIL busy_start_counts got cs=%0d mm=%0d want 0 18",
               csd, mmd);
    end
  endtask

  task automatic test_reset_abort();
    int mm0, n, dones;
    mm0 = mm_total;
    modulus = 8'd187;
    base = 8'd4;
    exponent = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mm_total - mm0 < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    nvec++;
    if (mm_total - mm0 < 2) begin
      nerr++;
      $display("FAIL abort_reach_sqr got %0d mm starts want 2",
               mm_total - mm0);
    end
    rst_n = 1'b0;
    dones = 0;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0) begin
      nerr++;
      $display("FAIL abort_busy got %b want 0", busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done) dones++;
    end
    nvec++;
    if (dones != 0 || busy !== 1'b0) begin
      nerr++;
      $display("FAIL abort_no_done got %0d dones busy %b want 0 0",
               dones, busy);
    end
    run_op(8'd187, 8'd4, 8'hC3, 0, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    nvec++;
    if (!got || res !== modpow(8'd187, 8'd4, 8'hC3) || csd != 1) begin
      nerr++;
      $display("FAIL abort_rerun got %0d cs=%0d want %0d cs=1",
               res, csd, modpow(8'd187, 8'd4, 8'hC3));
    end
    cache_m = 8'd187;
  endtask

  task automatic test_new_modulus();
    run_op(8'd221, 8'd5, 8'h03, 0, res, cyc, mmd, csd,
           b1, bdone, dnext, bnext, got);
    nvec++;
    if (!got || res !== 8'd125 || csd != 1) begin
      nerr++;
      $display("FAIL new_mod got %0d cs=%0d want 125 cs=1", res, csd);
    end
    cache_m = 8'd221;
  endtask

  task automatic test_random();
    logic [7:0] m, b, e, want;
    int wcs;
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 2) == 0) m = cache_m;
      else m = 8'($urandom_range(1, 127) * 2 + 1);
      b = 8'($urandom % int'(m));
      e = 8'($urandom);
      want = modpow(m, b, e);
      wcs = (m == cache_m) ? 0 : 1;
      run_op(m, b, e, 0, res, cyc, mmd, csd,
             b1, bdone, dnext, bnext, got);
      nvec++;
      if (!got || res !== want || csd != wcs || mmd != 18) begin
        nerr++;
        $display("FAIL rand m=%0d b=%0d e=%0d got %0d cs=%0d mm=%0d want %0d cs=%0d mm=18",
                 m, b, e, res, csd, mmd, want, wcs);
      end
      cache_m = m;
    end
  endtask

  task automatic test_handshake();
    nvec++;
    if (width_err != 0) begin
      nerr++;
      $display("FAIL pulse_width got %0d wide pulses want 0", width_err);
    end
    nvec++;
    if (stab_err != 0) begin
      nerr++;
      $display("FAIL operand_stable got %0d changes want 0", stab_err);
    end
  endtask

  initial begin
    test_reset();
    test_first();
    test_cached();
    test_latency();
    test_busy_start();
    test_reset_abort();
    test_new_modulus();
    test_random();
    test_handshake();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
